// File: rtl/wish_unpacker.sv
// rtl/wish_unpacker.sv - Wishbone-style width down-converter, one wide word out as NUM_PACK lanes
// Optional feature macro: WISH_UNPACK_BACK2BACK_EN (accept the next word on the final-lane ack)
module wish_unpacker #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  input  logic                           d_ack_i
);

  localparam int IW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PACK - 1);

  logic                           r_full;
  logic [IW-1:0]                  r_idx;
  logic [DATA_WIDTH*NUM_PACK-1:0] r_data;
  logic [TGC_WIDTH-1:0]           r_tgc;

  logic                  w_final;
  logic                  w_lane_done;
  logic                  w_accept;
  logic [IW-1:0]         w_sel;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [TGC_WIDTH-1:0]  w_tgc;

  assign w_final     = (r_idx == LAST_IDX);
  assign w_lane_done = r_full & d_ack_i;

`ifdef WISH_UNPACK_BACK2BACK_EN
  // Holding reg frees up in the same cycle its final lane is taken downstream
  assign s_stall_o = r_full & ~(d_ack_i & w_final);
`else
  assign s_stall_o = r_full;
`endif

  assign w_accept = s_stb_i & s_cyc_i & ~s_stall_o & ~rst_i;
  assign s_ack_o  = w_accept;

  // Physical lane position of the current output lane
  assign w_sel = (LITTLE_ENDIAN != 0) ? r_idx : (LAST_IDX - r_idx);

  // Lane multiplexer over the held word
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NUM_PACK; k++) begin
      if (w_sel == IW'(k)) begin
        w_lane = r_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Framing bits: first only on lane 0, last only on the final lane; upper bits ride along
  always_comb begin
    w_tgc    = r_tgc;
    w_tgc[0] = r_tgc[0] & (r_idx == '0);
    w_tgc[1] = r_tgc[1] & w_final;
  end

  assign d_stb_o = r_full;
  assign d_cyc_o = r_full;
  assign d_dat_o = r_full ? w_lane : '0;
  assign d_tgc_o = r_full ? w_tgc : '0;

  // Holding register and lane index; a new word always restarts at lane 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
      r_tgc  <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_idx  <= '0;
      r_data <= s_dat_i;
      r_tgc  <= s_tgc_i;
    end else if (w_lane_done) begin
      if (w_final) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wish_unpacker.sv
// tb/tb_wish_unpacker.sv - bench for wish_unpacker, big- and little-endian instances side by side
module tb_wish_unpacker;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int TW = 3;
`ifdef WISH_UNPACK_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, stb, cyc, d_ack;
  logic [DW*NP-1:0] dat;
  logic [TW-1:0]  tgc;

  logic ack_be, stall_be, dstb_be, dcyc_be;
  logic [DW-1:0] ddat_be;
  logic [TW-1:0] dtgc_be;
  logic ack_le, stall_le, dstb_le, dcyc_le;
  logic [DW-1:0] ddat_le;
  logic [TW-1:0] dtgc_le;

  wish_unpacker #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(0)) u_be (
    .clk_i(clk), .rst_i(rst), .s_stb_i(stb), .s_cyc_i(cyc), .s_dat_i(dat), .s_tgc_i(tgc),
    .s_ack_o(ack_be), .s_stall_o(stall_be), .d_stb_o(dstb_be), .d_cyc_o(dcyc_be),
    .d_dat_o(ddat_be), .d_tgc_o(dtgc_be), .d_ack_i(d_ack));

  wish_unpacker #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1)) u_le (
    .clk_i(clk), .rst_i(rst), .s_stb_i(stb), .s_cyc_i(cyc), .s_dat_i(dat), .s_tgc_i(tgc),
    .s_ack_o(ack_le), .s_stall_o(stall_le), .d_stb_o(dstb_le), .d_cyc_o(dcyc_le),
    .d_dat_o(ddat_le), .d_tgc_o(dtgc_le), .d_ack_i(d_ack));

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } lane_t;

  lane_t q_be[$];
  lane_t q_le[$];

  int checks = 0;
  int errors = 0;
  bit last_acc, last_stb;
  int lanes, span, n_acc;
  bit started;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW*NP-1:0] w, input logic [TW-1:0] t);
    for (int k = 0; k < NP; k++) begin
      lane_t b;
      lane_t l;
      b.t    = t;
      b.t[0] = t[0] && (k == 0);
      b.t[1] = t[1] && (k == NP - 1);
      l.t    = b.t;
      b.d    = w[(NP-1-k)*DW +: DW];
      l.d    = w[k*DW +: DW];
      q_be.push_back(b);
      q_le.push_back(l);
    end
  endtask

  function automatic bit exp_stall();
    return (q_be.size() != 0) && !(B2B && d_ack && q_be.size() == 1);
  endfunction

  function automatic bit exp_accept();
    return stb && cyc && !rst && !exp_stall();
  endfunction

  task automatic step();
    bit acc;
    bit vld;
    @(negedge clk);
    acc = exp_accept();
    vld = (q_be.size() != 0);
    chk("s_ack_be", {31'd0, ack_be}, {31'd0, acc});
    chk("s_ack_le", {31'd0, ack_le}, {31'd0, acc});
    chk("s_stall_be", {31'd0, stall_be}, {31'd0, exp_stall()});
    chk("s_stall_le", {31'd0, stall_le}, {31'd0, exp_stall()});
    chk("d_stb_be", {31'd0, dstb_be}, {31'd0, vld});
    chk("d_stb_le", {31'd0, dstb_le}, {31'd0, vld});
    chk("d_cyc_be", {31'd0, dcyc_be}, {31'd0, vld});
    chk("d_cyc_le", {31'd0, dcyc_le}, {31'd0, vld});
    if (vld) begin
      chk("d_dat_be", {24'd0, ddat_be}, {24'd0, q_be[0].d});
      chk("d_tgc_be", {29'd0, dtgc_be}, {29'd0, q_be[0].t});
      chk("d_dat_le", {24'd0, ddat_le}, {24'd0, q_le[0].d});
      chk("d_tgc_le", {29'd0, dtgc_le}, {29'd0, q_le[0].t});
    end
    last_acc = acc;
    last_stb = dstb_be;
    @(posedge clk);
    if (rst) begin
      q_be.delete();
      q_le.delete();
    end else begin
      if (d_ack && q_be.size() != 0) begin
        void'(q_be.pop_front());
        void'(q_le.pop_front());
      end
      if (acc) push_word(dat, tgc);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; d_ack = 1'b0; dat = '0; tgc = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_d_stb", {31'd0, dstb_be}, 32'd0);
    chk("rst_d_dat", {24'd0, ddat_be}, 32'd0);
    chk("rst_d_tgc", {29'd0, dtgc_be}, 32'd0);
    chk("rst_stall", {31'd0, stall_be}, 32'd0);

    // Single word, first flag, continuous ack
    stb = 1'b1; cyc = 1'b1; dat = 32'h11223344; tgc = 3'b001; d_ack = 1'b1;
    step();
    stb = 1'b0;
    chk("first_lane_be", {24'd0, ddat_be}, 32'h11);
    chk("first_lane_le", {24'd0, ddat_le}, 32'h44);
    chk("first_tgc_be", {29'd0, dtgc_be}, 32'h1);
    for (int i = 0; i < 5; i++) step();

    // Last flag plus pass-through bit, with a 3-cycle downstream hold mid-word
    stb = 1'b1; dat = 32'h11223344; tgc = 3'b110;
    step();
    stb = 1'b0;
    step();
    d_ack = 1'b0; stb = 1'b1; dat = 32'hAABBCCDD; tgc = 3'b011;
    for (int i = 0; i < 3; i++) step();
    chk("hold_dat_be", {24'd0, ddat_be}, 32'h22);
    chk("hold_dat_le", {24'd0, ddat_le}, 32'h33);
    chk("hold_stb", {31'd0, dstb_be}, 32'd1);
    d_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) break;
    end
    stb = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Reset after two lanes
    stb = 1'b1; dat = 32'h55667788; tgc = 3'b001;
    step();
    stb = 1'b0;
    step();
    step();
    rst = 1'b1; stb = 1'b1;
    step();
    rst = 1'b0; stb = 1'b0;
    chk("rst_mid_stb", {31'd0, dstb_be}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall_be}, 32'd0);
    stb = 1'b1; dat = 32'h99AABBCC; tgc = 3'b001;
    step();
    stb = 1'b0;
    chk("restart_lane0", {24'd0, ddat_be}, 32'h99);
    chk("restart_tgc", {29'd0, dtgc_be}, 32'h1);
    for (int i = 0; i < 5; i++) step();

    // Two words offered back to back with continuous ack
    stb = 1'b1; cyc = 1'b1; d_ack = 1'b1; dat = 32'h01020304; tgc = 3'b001;
    lanes = 0; span = 0; n_acc = 0; started = 1'b0;
    for (int c = 0; c < 30 && lanes < 8; c++) begin
      step();
      if (last_acc) begin
        n_acc++;
        if (n_acc == 1) begin dat = 32'h05060708; tgc = 3'b010; end
        if (n_acc == 2) stb = 1'b0;
      end
      if (last_stb) begin started = 1'b1; lanes++; end
      if (started) span++;
    end
    stb = 1'b0;
    chk("b2b_lanes", lanes, 32'd8);
    chk("b2b_span", span, B2B ? 32'd8 : 32'd9);
    for (int i = 0; i < 3; i++) step();

    // Strobe without cycle is never accepted
    stb = 1'b1; cyc = 1'b0; dat = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) step();
    chk("cyc0_stb", {31'd0, dstb_be}, 32'd0);
    stb = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stb   = ($urandom_range(0, 2) != 0);
      cyc   = ($urandom_range(0, 5) != 0);
      d_ack = ($urandom_range(0, 3) != 0);
      dat   = $urandom;
      tgc   = TW'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
